// File: rtl/urv_arb_pkg.sv
// Shared types and constants for the uRV memory arbiter.
// MMIO addresses are decoded only when URV_ARB_MMIO_EN is defined.
package urv_arb_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_FETCH,
      S_LOAD,
      S_STORE
   } arb_state_t;

   localparam logic [31:0] MMIO_CONSOLE_ADDR   = 32'h0010_0000;
   localparam logic [31:0] MMIO_TEST_DONE_ADDR = 32'h0010_0004;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  sel;
      logic        is_store;
   } arb_req_t;

   function automatic logic is_mmio(input logic [31:0] addr);
      return (addr == MMIO_CONSOLE_ADDR) || (addr == MMIO_TEST_DONE_ADDR);
   endfunction

endpackage

// File: rtl/urv_mem_arbiter_if.sv
// Single-port RAM bus between the arbiter (master) and the RAM (slave).
interface urv_mem_arbiter_if #(
   parameter int AW = 14
);
   logic [AW-1:0] mem_addr_o;
   logic [3:0]    mem_we_o;
   logic [31:0]   mem_wdata_o;
   logic [31:0]   mem_rdata_i;

   modport master (output mem_addr_o, output mem_we_o, output mem_wdata_o, input mem_rdata_i);
   modport slave  (input mem_addr_o, input mem_we_o, input mem_wdata_o, output mem_rdata_i);
endinterface

// File: rtl/urv_arb_req_buf.sv
// One-entry holding buffer for a data request that arrives while the arbiter is busy.
// A push while already full is dropped.
module urv_arb_req_buf
   import urv_arb_pkg::*;
(
   input  logic     clk_i,
   input  logic     rst_n_i,
   input  logic     push_i,
   input  arb_req_t push_req_i,
   input  logic     pop_i,
   output logic     valid_o,
   output arb_req_t req_o
);

   logic     valid_q;
   arb_req_t req_q;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         valid_q <= 1'b0;
         req_q   <= '0;
      end else if (push_i && !valid_q) begin
         valid_q <= 1'b1;
         req_q   <= push_req_i;
      end else if (pop_i) begin
         valid_q <= 1'b0;
      end
   end

   assign valid_o = valid_q;
   assign req_o   = req_q;

endmodule

// File: rtl/urv_mem_arbiter.sv
// Arbitrates one single-port RAM between uRV instruction fetch and data accesses.
// Optional MMIO console/test-done registers are enabled by URV_ARB_MMIO_EN.
module urv_mem_arbiter
   import urv_arb_pkg::*;
#(
   parameter  int g_mem_words = 16384,
   localparam int AW          = $clog2(g_mem_words)
) (
   input  logic                     clk_i,
   input  logic                     rst_n_i,
   input  logic [31:0]              im_addr_i,
   output logic [31:0]              im_data_o,
   output logic                     im_valid_o,
   input  logic [31:0]              dm_addr_i,
   input  logic [31:0]              dm_data_s_i,
   input  logic [3:0]               dm_data_select_i,
   input  logic                     dm_store_i,
   input  logic                     dm_load_i,
   output logic [31:0]              dm_data_l_o,
   output logic                     dm_load_done_o,
   output logic                     dm_store_done_o,
   output logic                     dm_ready_o,
   urv_mem_arbiter_if.master        mem,
   output logic                     console_valid_o,
   output logic [7:0]               console_data_o,
   output logic                     test_done_o
);

   arb_state_t state_q, state_d;
   arb_req_t   grant_req, buf_req, push_req;
   logic       grant_data, buf_valid, buf_push, buf_pop;
   logic       issue, mmio_hit;
   logic [31:0] ld_value, ld_data_q;
   logic       unused_addr_bits;

   // Buffered request wins, then live store, then live load, else fetch.
   always_comb begin
      grant_req  = '0;
      grant_data = 1'b0;
      if (buf_valid) begin
         grant_req  = buf_req;
         grant_data = 1'b1;
      end else if (dm_store_i) begin
         grant_req  = '{addr: dm_addr_i, wdata: dm_data_s_i, sel: dm_data_select_i, is_store: 1'b1};
         grant_data = 1'b1;
      end else if (dm_load_i) begin
         grant_req  = '{addr: dm_addr_i, wdata: dm_data_s_i, sel: dm_data_select_i, is_store: 1'b0};
         grant_data = 1'b1;
      end else begin
         grant_req.addr = im_addr_i;
      end
   end

   always_comb begin
      state_d = S_IDLE;
      if (state_q == S_IDLE) begin
         if (!grant_data)             state_d = S_FETCH;
         else if (grant_req.is_store) state_d = S_STORE;
         else                         state_d = S_LOAD;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q   <= S_IDLE;
         ld_data_q <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == S_LOAD) ld_data_q <= ld_value;
      end
   end

   // A store+load pair is recorded as a store; the load half is discarded.
   assign push_req = '{addr: dm_addr_i, wdata: dm_data_s_i, sel: dm_data_select_i, is_store: dm_store_i};
   assign buf_push = (state_q != S_IDLE) && (dm_store_i || dm_load_i);
   assign buf_pop  = (state_q == S_IDLE) && buf_valid;

   urv_arb_req_buf u_req_buf (
      .clk_i      (clk_i),
      .rst_n_i    (rst_n_i),
      .push_i     (buf_push),
      .push_req_i (push_req),
      .pop_i      (buf_pop),
      .valid_o    (buf_valid),
      .req_o      (buf_req)
   );

   // Gating with rst_n_i keeps the RAM bus quiet the instant reset asserts.
   assign issue           = rst_n_i && (state_q == S_IDLE);
   assign mem.mem_addr_o  = issue ? grant_req.addr[AW+1:2] : '0;
   assign mem.mem_we_o    = (issue && grant_data && grant_req.is_store && !mmio_hit) ? grant_req.sel : 4'b0;
   assign mem.mem_wdata_o = (issue && grant_data && grant_req.is_store) ? grant_req.wdata : '0;

   assign im_valid_o      = (state_q == S_FETCH);
   assign im_data_o       = (state_q == S_FETCH) ? mem.mem_rdata_i : '0;
   assign dm_load_done_o  = (state_q == S_LOAD);
   assign dm_store_done_o = (state_q == S_STORE);
   assign dm_data_l_o     = (state_q == S_LOAD) ? ld_value : ld_data_q;
   assign dm_ready_o      = issue && !buf_valid;

`ifdef URV_ARB_MMIO_EN
   logic       console_valid_q, test_done_q, mmio_ld_q, store_issue;
   logic [7:0] console_data_q;

   assign mmio_hit    = grant_data && is_mmio(grant_req.addr);
   assign store_issue = issue && grant_data && grant_req.is_store;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         console_valid_q <= 1'b0;
         console_data_q  <= '0;
         test_done_q     <= 1'b0;
         mmio_ld_q       <= 1'b0;
      end else begin
         console_valid_q <= store_issue && (grant_req.addr == MMIO_CONSOLE_ADDR);
         if (store_issue && (grant_req.addr == MMIO_CONSOLE_ADDR))
            console_data_q <= grant_req.wdata[7:0];
         if (store_issue && (grant_req.addr == MMIO_TEST_DONE_ADDR))
            test_done_q <= 1'b1;
         mmio_ld_q <= issue && grant_data && !grant_req.is_store && mmio_hit;
      end
   end

   assign ld_value        = mmio_ld_q ? '0 : mem.mem_rdata_i;
   assign console_valid_o = console_valid_q;
   assign console_data_o  = console_data_q;
   assign test_done_o     = test_done_q;
`else
   assign mmio_hit        = 1'b0;
   assign ld_value        = mem.mem_rdata_i;
   assign console_valid_o = 1'b0;
   assign console_data_o  = '0;
   assign test_done_o     = 1'b0;
`endif

   assign unused_addr_bits = ^{grant_req.addr[31:AW+2], grant_req.addr[1:0]};

endmodule

// File: doc/urv_mem_arbiter.md
URV_MEM_ARBITER -- requirements
Module: urv_mem_arbiter

Interface
REQ-001 SHALL have parameter g_mem_words, default 16384, RAM depth in 32-bit words (power of two); AW = clog2(g_mem_words).
REQ-002 clk_i  in  1  single clock; all state on rising edge.
REQ-003 rst_n_i  in  1  reset, asynchronous, active-low.
REQ-004 im_addr_i  in  32  CPU fetch byte address.
REQ-005 im_data_o  out  32  fetched instruction word.
REQ-006 im_valid_o  out  1  im_data_o valid, one-cycle pulse.
REQ-007 dm_addr_i  in  32  data byte address.
REQ-008 dm_data_s_i  in  32  store data.
REQ-009 dm_data_select_i  in  4  store byte enables.
REQ-010 dm_store_i / dm_load_i  in  1 each  data request pulses.
REQ-011 dm_data_l_o  out  32  load data.
REQ-012 dm_load_done_o / dm_store_done_o  out  1 each  completion pulses.
REQ-013 dm_ready_o  out  1  arbiter can accept a new data request.
REQ-014 mem_addr_o  out  AW  RAM word address; mem_we_o  out  4  byte write enables; mem_wdata_o  out  32; mem_rdata_i  in  32, valid one cycle after address.
REQ-015 console_valid_o  out  1, console_data_o  out  8, test_done_o  out  1  MMIO outputs (see Configuration).

Function
REQ-016 FSM states SHALL be IDLE, FETCH, LOAD, STORE; every non-IDLE state lasts exactly one cycle, then returns to IDLE.
REQ-017 In IDLE, grant priority SHALL be: buffered data request, then live dm_store_i, then live dm_load_i, else fetch of im_addr_i.
REQ-018 Granted access SHALL drive mem_addr_o/mem_we_o/mem_wdata_o combinationally in the IDLE cycle N; word address = byte address[AW+1:2] (modulo wrap).
REQ-019 Fetch: in cycle N+1 (FETCH) im_valid_o=1, im_data_o=mem_rdata_i; im_addr_i changes after N ignored.
REQ-020 Load: in cycle N+1 (LOAD) dm_load_done_o=1, dm_data_l_o=mem_rdata_i; dm_data_l_o holds value until next load.
REQ-021 Store: mem_we_o=dm_data_select_i in cycle N only; dm_store_done_o=1 in cycle N+1.
REQ-022 dm_ready_o SHALL equal (state==IDLE) and buffer empty.
REQ-023 A data request arriving while not IDLE SHALL be captured with its addr/data/select in a 1-entry buffer and served at next IDLE.
REQ-024 A request arriving while buffer full SHALL be dropped (protocol violation; CPU must honour dm_ready_o).
REQ-025 dm_store_i and dm_load_i together SHALL execute the store; load is dropped.
REQ-026 Store with dm_data_select_i=0 SHALL complete with no RAM write.

Reset
REQ-027 On rst_n_i low: state IDLE, buffer empty, all outputs 0, mem_we_o=0, immediately and asynchronously.
REQ-028 Reset mid-access SHALL abort it with no done/valid pulse; a store already in cycle N with reset asserted SHALL NOT write.
REQ-029 First grant SHALL occur in the first cycle after rst_n_i deasserts.

Configuration
REQ-030 Macro URV_ARB_MMIO_EN defined: store to 32'h0010_0000 SHALL pulse console_valid_o in cycle N+1 with console_data_o=dm_data_s_i[7:0]; store to 32'h0010_0004 SHALL set test_done_o sticky until reset; neither writes RAM; loads from them return 0; done pulses unchanged.
REQ-031 Macro undefined: console_valid_o, console_data_o, test_done_o tied 0; those addresses are ordinary modulo RAM accesses.

Structure
REQ-032 Package urv_arb_pkg SHALL hold state enum, MMIO address constants, request record type (addr, wdata, sel, is_store).
REQ-033 Sub-module urv_arb_req_buf SHALL implement the 1-entry data request buffer.

Verification
REQ-034 Reset release, RAM[0]=32'h0000_0013, im_addr_i=0 -> im_valid_o pulses every 2 cycles with 32'h0000_0013.
REQ-035 Store 32'hDEAD_BEEF sel 4'b0011 to 0x40 then load 0x40, RAM[16] initially 0 -> dm_data_l_o=32'h0000_BEEF, each done one cycle after grant.
REQ-036 dm_load_i pulsed during FETCH -> buffered, dm_ready_o low, LOAD served next IDLE before any fetch.
REQ-037 Store to byte address 4*g_mem_words+8 -> RAM[2] written (wrap).
REQ-038 With URV_ARB_MMIO_EN: store 'A' to 0x0010_0000 -> console_valid_o 1 cycle, console_data_o=8'h41, RAM unchanged; store to 0x0010_0004 -> test_done_o stays 1.
REQ-039 rst_n_i low during STORE issue cycle -> no RAM write, no done pulse, outputs 0.
